// File: rtl/cl_pkg.sv
// Shared definitions for the Camera Link-style receive path.
//   - Control-bit positions inside the 28-bit deserialized word.
//   - Bit indices of the sticky error status vector.
//   - Deframer FSM state encoding.
package cl_pkg;

  localparam int unsigned FVAL_BIT = 25;
  localparam int unsigned LVAL_BIT = 24;
  localparam int unsigned DVAL_BIT = 26;

  localparam int unsigned ERR_ORPHAN = 0;
  localparam int unsigned ERR_TRUNC  = 1;
  localparam int unsigned ERR_WIDTH  = 2;
  localparam int unsigned ERR_GEOM   = 3;

  typedef enum logic [1:0] {
    SYNC,
    GAP,
    FRAME,
    LINE
  } cl_state_e;

endpackage

// File: rtl/cl_unpack.sv
// Combinational unpacker for the camera transmitter bit mapping.
// Ports:
//   din   in  28  deserialized word, bit order as transmitted
//   fval  out 1   frame valid
//   lval  out 1   line valid
//   pix   out 16  pixel data
// DVAL and the spare bits din[23:15] carry nothing for this receiver.
module cl_unpack
  import cl_pkg::*;
(
  input  logic [27:0] din,
  output logic        fval,
  output logic        lval,
  output logic [15:0] pix
);

  assign fval = din[FVAL_BIT];
  assign lval = din[LVAL_BIT];

  assign pix[4:0]   = din[4:0];
  assign pix[5]     = din[6];
  assign pix[6]     = din[27];
  assign pix[7]     = din[5];
  assign pix[10:8]  = din[9:7];
  assign pix[13:11] = din[14:12];
  assign pix[15:14] = din[11:10];

  logic unused_bits;
  assign unused_bits = ^{din[DVAL_BIT], din[23:15]};

endmodule

// File: rtl/cl_rx_deframer.sv
// Receive deframer: recovers FVAL/LVAL framing from the deserialized word and
// emits a 16-bit pixel stream with line/frame markers, frame geometry and
// sticky protocol error flags.
// Ports:
//   clk       in  1   word clock
//   init      in  1   synchronous active-high reset
//   din       in  28  deserialized word
//   din_vld   in  1   din valid; invalid cycles change no state
//   pix       out 16  pixel data (held when pix_vld is low)
//   pix_vld   out 1   pixel valid
//   sol, eol  out 1   first/last pixel of line (eol alone on truncation)
//   sof, eof  out 1   first pixel of frame / frame end pulse
//   frm_w     out CW  width of last completed frame
//   frm_h     out CW  line count of last completed frame
//   geom_vld  out 1   pulse when frm_w/frm_h update
//   err_stat  out 4   sticky {geom, width, trunc, orphan}
//   err_clr   in  1   clears err_stat; same-cycle set events win
module cl_rx_deframer
  import cl_pkg::*;
#(
  parameter int unsigned CW = 11
) (
  input  logic          clk,
  input  logic          init,
  input  logic [27:0]   din,
  input  logic          din_vld,
  output logic [15:0]   pix,
  output logic          pix_vld,
  output logic          sol,
  output logic          eol,
  output logic          sof,
  output logic          eof,
  output logic [CW-1:0] frm_w,
  output logic [CW-1:0] frm_h,
  output logic          geom_vld,
  output logic [3:0]    err_stat,
  input  logic          err_clr
);

  logic        u_fval, u_lval;
  logic [15:0] u_pix;

  cl_unpack u_unpack (
    .din  (din),
    .fval (u_fval),
    .lval (u_lval),
    .pix  (u_pix)
  );

  cl_state_e   state_q, state_d;
  // One-word holding stage: eol for a pixel is only known from the next word.
  // A pixel is pending exactly while in LINE.
  logic [15:0] hold_pix_q, hold_pix_d;
  logic        hold_sol_q, hold_sol_d;
  logic        hold_sof_q, hold_sof_d;

  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic [CW-1:0] line_cnt_q, line_cnt_d;
  logic [CW-1:0] ref_w_q, ref_w_d;
  logic          have_prev_q, have_prev_d;

  logic [15:0]   pix_q, pix_d;
  logic          pix_vld_q, pix_vld_d;
  logic          sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
  logic          geom_vld_q, geom_vld_d;
  logic [CW-1:0] frm_w_q, frm_w_d, frm_h_q, frm_h_d;
  logic [3:0]    err_q, err_d, err_set;
  logic          frame_end;

  localparam logic [CW-1:0] CntMax = '1;

  always_comb begin
    state_d     = state_q;
    hold_pix_d  = hold_pix_q;
    hold_sol_d  = hold_sol_q;
    hold_sof_d  = hold_sof_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    ref_w_d     = ref_w_q;
    have_prev_d = have_prev_q;
    frm_w_d     = frm_w_q;
    frm_h_d     = frm_h_q;
    pix_d       = pix_q;
    pix_vld_d   = 1'b0;
    sol_d       = 1'b0;
    eol_d       = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    geom_vld_d  = 1'b0;
    err_set     = '0;
    frame_end   = 1'b0;

    if (din_vld) begin
      case (state_q)
        SYNC: begin
          if (!u_fval) state_d = GAP;
        end
        GAP: begin
          if (u_fval) begin
            state_d    = FRAME;
            line_cnt_d = '0;
            ref_w_d    = '0;
          end else if (u_lval) begin
            err_set[ERR_ORPHAN] = 1'b1;
          end
        end
        FRAME: begin
          if (!u_fval) begin
            state_d   = GAP;
            frame_end = 1'b1;
          end else if (u_lval) begin
            state_d    = LINE;
            hold_pix_d = u_pix;
            hold_sol_d = 1'b1;
            hold_sof_d = (line_cnt_q == '0);
            pix_cnt_d  = CW'(1);
          end
        end
        LINE: begin
          if (!u_fval) begin
            // Truncated line: pending pixel is dropped, eol and eof pulse bare.
            state_d            = GAP;
            eol_d              = 1'b1;
            err_set[ERR_TRUNC] = 1'b1;
            frame_end          = 1'b1;
          end else begin
            pix_d     = hold_pix_q;
            pix_vld_d = 1'b1;
            sol_d     = hold_sol_q;
            sof_d     = hold_sof_q;
            if (u_lval) begin
              hold_pix_d = u_pix;
              hold_sol_d = 1'b0;
              hold_sof_d = 1'b0;
              pix_cnt_d  = (pix_cnt_q == CntMax) ? pix_cnt_q : pix_cnt_q + CW'(1);
            end else begin
              state_d    = FRAME;
              eol_d      = 1'b1;
              line_cnt_d = (line_cnt_q == CntMax) ? line_cnt_q : line_cnt_q + CW'(1);
              if (line_cnt_q == '0) begin
                ref_w_d = pix_cnt_q;
              end else if (pix_cnt_q != ref_w_q) begin
                err_set[ERR_WIDTH] = 1'b1;
              end
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end

    if (frame_end) begin
      eof_d       = 1'b1;
      geom_vld_d  = 1'b1;
      frm_w_d     = ref_w_q;
      frm_h_d     = line_cnt_q;
      have_prev_d = 1'b1;
      if (have_prev_q && ((ref_w_q != frm_w_q) || (line_cnt_q != frm_h_q))) begin
        err_set[ERR_GEOM] = 1'b1;
      end
    end

    err_d = (err_clr ? 4'b0000 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= SYNC;
      hold_pix_q  <= '0;
      hold_sol_q  <= 1'b0;
      hold_sof_q  <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      ref_w_q     <= '0;
      have_prev_q <= 1'b0;
      pix_q       <= '0;
      pix_vld_q   <= 1'b0;
      sol_q       <= 1'b0;
      eol_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      geom_vld_q  <= 1'b0;
      frm_w_q     <= '0;
      frm_h_q     <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_pix_q  <= hold_pix_d;
      hold_sol_q  <= hold_sol_d;
      hold_sof_q  <= hold_sof_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      ref_w_q     <= ref_w_d;
      have_prev_q <= have_prev_d;
      pix_q       <= pix_d;
      pix_vld_q   <= pix_vld_d;
      sol_q       <= sol_d;
      eol_q       <= eol_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      geom_vld_q  <= geom_vld_d;
      frm_w_q     <= frm_w_d;
      frm_h_q     <= frm_h_d;
      err_q       <= err_d;
    end
  end

  assign pix      = pix_q;
  assign pix_vld  = pix_vld_q;
  assign sol      = sol_q;
  assign eol      = eol_q;
  assign sof      = sof_q;
  assign eof      = eof_q;
  assign geom_vld = geom_vld_q;
  assign frm_w    = frm_w_q;
  assign frm_h    = frm_h_q;
  assign err_stat = err_q;

endmodule

// File: tb/tb_cl_rx_deframer.sv
// Directed self-checking bench for cl_rx_deframer.
module tb_cl_rx_deframer;

  localparam int unsigned CW = 11;

  logic          clk = 1'b0;
  logic          init;
  logic [27:0]   din;
  logic          din_vld;
  logic [15:0]   pix;
  logic          pix_vld, sol, eol, sof, eof, geom_vld;
  logic [CW-1:0] frm_w, frm_h;
  logic [3:0]    err_stat;
  logic          err_clr;

  cl_rx_deframer #(.CW(CW)) dut (
    .clk      (clk),
    .init     (init),
    .din      (din),
    .din_vld  (din_vld),
    .pix      (pix),
    .pix_vld  (pix_vld),
    .sol      (sol),
    .eol      (eol),
    .sof      (sof),
    .eof      (eof),
    .frm_w    (frm_w),
    .frm_h    (frm_h),
    .geom_vld (geom_vld),
    .err_stat (err_stat),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int geom_cnt = 0;
  int idle_bad = 0;
  logic [20:0] ev_q[$];
  logic [20:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Transmitter-side mapping of pixel and control bits onto the word.
  function automatic logic [27:0] pack(input logic f, input logic l, input logic [15:0] p);
    logic [27:0] d;
    d         = '0;
    d[4:0]    = p[4:0];
    d[5]      = p[7];
    d[6]      = p[5];
    d[9:7]    = p[10:8];
    d[11:10]  = p[15:14];
    d[14:12]  = p[13:11];
    d[27]     = p[6];
    d[25]     = f;
    d[24]     = l;
    d[26]     = 1'b1;
    d[23:15]  = 9'h15A;
    return d;
  endfunction

  task automatic sample();
    if (!din_vld && (pix_vld | sol | eol | sof | eof | geom_vld)) idle_bad++;
    if (geom_vld) geom_cnt++;
    if (pix_vld | sol | eol | sof | eof)
      ev_q.push_back({pix_vld, sof, sol, eol, eof, pix_vld ? pix : 16'h0000});
  endtask

  task automatic send(input logic f, input logic l, input logic [15:0] p, input logic v);
    din     = v ? pack(f, l, p) : 28'($urandom);
    din_vld = v;
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic clear_mon();
    ev_q.delete();
    geom_cnt = 0;
    idle_bad = 0;
  endtask

  task automatic idle_if(input logic tog);
    if (tog) send(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic send_frame(input int w, input int h, input logic [15:0] base, input logic tog);
    logic [15:0] pv;
    send(1'b1, 1'b0, 16'h0, 1'b1); idle_if(tog);
    for (int l = 0; l < h; l++) begin
      for (int c = 0; c < w; c++) begin
        pv = base + 16'(l * 16 + c);
        send(1'b1, 1'b1, pv, 1'b1); idle_if(tog);
      end
      send(1'b1, 1'b0, 16'h0, 1'b1); idle_if(tog);
    end
    send(1'b0, 1'b0, 16'h0, 1'b1); idle_if(tog);
  endtask

  task automatic build_exp(input int w, input int h, input logic [15:0] base);
    logic [15:0] pv;
    logic        fs, ls, le;
    exp_q.delete();
    for (int l = 0; l < h; l++) begin
      for (int c = 0; c < w; c++) begin
        pv = base + 16'(l * 16 + c);
        fs = (l == 0) && (c == 0);
        ls = (c == 0);
        le = (c == w - 1);
        exp_q.push_back({1'b1, fs, ls, le, 1'b0, pv});
      end
    end
    exp_q.push_back({5'b00001, 16'h0000});
  endtask

  task automatic check_events(input string tag);
    int mism;
    int n;
    mism = 0;
    check({tag, "_evcnt"}, ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (ev_q[i] !== exp_q[i]) begin
        if (mism == 0) $display("FAIL %s_ev[%0d]: got %0h expected %0h", tag, i, ev_q[i], exp_q[i]);
        mism++;
      end
    end
    check({tag, "_evseq"}, mism, 0);
  endtask

  task automatic do_init();
    din     = pack(1'b1, 1'b1, 16'hBEEF);
    din_vld = 1'b1;
    init    = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    check("init_abort_eof", eof, 1'b0);
    check("init_abort_vld", pix_vld, 1'b0);
    clear_mon();
  endtask

  initial begin
    int npix;
    init    = 1'b1;
    din     = '0;
    din_vld = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix", pix, 16'h0);
    check("rst_vld", {pix_vld, sol, eol, sof, eof, geom_vld}, 6'b0);
    check("rst_frm_w", frm_w, 0);
    check("rst_frm_h", frm_h, 0);
    check("rst_err", err_stat, 4'b0);
    init = 1'b0;

    // Start a frame, reset mid-line, keep fval high: nothing may come out.
    send(1'b0, 1'b0, 16'h0, 1'b1);
    send(1'b1, 1'b0, 16'h0, 1'b1);
    send(1'b1, 1'b1, 16'h0011, 1'b1);
    send(1'b1, 1'b1, 16'h0022, 1'b1);
    do_init();
    send(1'b1, 1'b1, 16'h0033, 1'b1);
    send(1'b1, 1'b0, 16'h0, 1'b1);
    send(1'b1, 1'b1, 16'h0044, 1'b1);
    send(1'b1, 1'b0, 16'h0, 1'b1);
    check("sync_discard", ev_q.size(), 0);
    send(1'b0, 1'b0, 16'h0, 1'b1);
    clear_mon();
    build_exp(8, 4, 16'h1000);
    send_frame(8, 4, 16'h1000, 1'b0);
    check_events("f8x4");
    check("f8x4_frm_w", frm_w, 8);
    check("f8x4_frm_h", frm_h, 4);
    check("f8x4_geom_cnt", geom_cnt, 1);
    check("f8x4_err", err_stat, 4'b0000);

    // Pixel mapping and latency: A55A appears after the following valid word.
    send(1'b1, 1'b0, 16'h0, 1'b1);
    send(1'b1, 1'b1, 16'hA55A, 1'b1);
    check("a55a_early", pix_vld, 1'b0);
    send(1'b1, 1'b1, 16'h1234, 1'b1);
    check("a55a_pix", pix, 16'hA55A);
    check("a55a_strb", {pix_vld, sof, sol, eol}, 4'b1110);
    send(1'b1, 1'b0, 16'h0, 1'b1);
    check("p1234_pix", pix, 16'h1234);
    check("p1234_strb", {pix_vld, sof, sol, eol}, 4'b1001);
    send(1'b0, 1'b0, 16'h0, 1'b1);
    check("f2x1_eof", {eof, geom_vld}, 2'b11);
    check("f2x1_geom", {frm_w, frm_h}, {11'd2, 11'd1});
    check("f2x1_err", err_stat, 4'b1000);
    err_clr = 1'b1;
    send(1'b0, 1'b0, 16'h0, 1'b0);
    err_clr = 1'b0;
    check("errclr", err_stat, 4'b0000);

    // Geometry change across two frames after init.
    do_init();
    send(1'b0, 1'b0, 16'h0, 1'b1);
    send_frame(8, 4, 16'h2000, 1'b0);
    check("g1_err", err_stat, 4'b0000);
    send_frame(8, 5, 16'h3000, 1'b0);
    check("g2_err", err_stat, 4'b1000);
    check("g2_frm_h", frm_h, 5);
    check("g2_frm_w", frm_w, 8);

    // fval drops during line 2 after 3 pixels.
    err_clr = 1'b1;
    send(1'b0, 1'b0, 16'h0, 1'b0);
    err_clr = 1'b0;
    clear_mon();
    send(1'b1, 1'b0, 16'h0, 1'b1);
    for (int c = 0; c < 8; c++) send(1'b1, 1'b1, 16'(16'h4000 + c), 1'b1);
    send(1'b1, 1'b0, 16'h0, 1'b1);
    for (int c = 0; c < 3; c++) send(1'b1, 1'b1, 16'(16'h4010 + c), 1'b1);
    send(1'b0, 1'b0, 16'h0, 1'b1);
    check("trunc_last", ev_q[$], {5'b00011, 16'h0000});
    npix = 0;
    foreach (ev_q[i]) if (ev_q[i][20]) npix++;
    check("trunc_npix", npix, 10);
    check("trunc_err", err_stat, 4'b1010);
    check("trunc_frm_h", frm_h, 1);
    check("trunc_frm_w", frm_w, 8);

    // Orphan lval outside a frame.
    err_clr = 1'b1;
    send(1'b0, 1'b0, 16'h0, 1'b0);
    err_clr = 1'b0;
    clear_mon();
    send(1'b0, 1'b1, 16'hFFFF, 1'b1);
    send(1'b0, 1'b1, 16'hFFFF, 1'b1);
    check("orph_noevt", ev_q.size(), 0);
    check("orph_err", err_stat, 4'b0001);
    err_clr = 1'b1;
    send(1'b0, 1'b0, 16'h0, 1'b0);
    check("orph_clr", err_stat, 4'b0000);
    send(1'b0, 1'b1, 16'hFFFF, 1'b1);
    err_clr = 1'b0;
    check("orph_set_wins", err_stat, 4'b0001);

    // Sparse din_vld: same stream, only gaps added.
    do_init();
    send(1'b0, 1'b0, 16'h0, 1'b1);
    clear_mon();
    build_exp(4, 2, 16'h5000);
    send_frame(4, 2, 16'h5000, 1'b1);
    check_events("sparse");
    check("sparse_idle", idle_bad, 0);
    check("sparse_geom", {frm_w, frm_h}, {11'd4, 11'd2});
    check("sparse_geom_cnt", geom_cnt, 1);
    check("sparse_err", err_stat, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cl_rx_deframer.md
# cl_rx_deframer

Camera Link-style receive deframer for the 28-bit parallel word recovered by the 7:1 LVDS deserializer on the far end of the camera's X0..X3/XCLK link. It unpacks the fixed bit mapping used by the camera transmitter, recovers FVAL/LVAL framing, and emits a 16-bit pixel stream with start/end-of-line and start/end-of-frame markers. It also measures frame geometry and flags protocol errors. It sits directly after the deserializer in the grabber/test-receiver path.

## Interface
Parameters:
- CW, 11, width of pixel/line counters and geometry outputs (matches ah/av width)

Ports:
- clk  in  1  deserialized word clock (clk1x domain)
- init  in  1  synchronous active-high reset
- din  in  28  deserialized word, bit order as transmitted
- din_vld  in  1  din valid this cycle; when low the cycle is ignored, with no state change
- pix  out  16  recovered pixel data
- pix_vld  out  1  pix valid (inside LVAL within FVAL)
- sol, eol  out  1  first/last pixel of a line, qualified by pix_vld; eol may also pulse alone (see truncation)
- sof, eof  out  1  first pixel of frame / frame end pulse
- frm_w, frm_h  out  CW  geometry of last completed frame
- geom_vld  out  1  one-cycle pulse when frm_w/frm_h update
- err_stat  out  4  sticky errors {geom, width, trunc, orphan}
- err_clr  in  1  clears err_stat (set events in the same cycle win)

## Operation
Unpack (combinational) from din:
- fval = din[25], lval = din[24], dval = din[26] (ignored), din[23:15] ignored
- pix[4:0] = din[4:0], pix[7] = din[5], pix[5] = din[6], pix[10:8] = din[9:7], pix[15:14] = din[11:10], pix[13:11] = din[14:12], pix[6] = din[27]

FSM, advanced only on din_vld:
- SYNC (after init): discard everything until fval = 0 is seen, then go to GAP. A partial frame is never emitted.
- GAP (fval = 0): fval = 1 -> FRAME. lval = 1 with fval = 0 -> set err orphan, stay.
- FRAME (fval = 1, between lines): lval = 1 -> LINE, emit first pixel with sol; the first line of the frame also asserts sof. fval = 0 -> GAP, pulse eof, update geometry.
- LINE: lval = 1 -> emit pixel. lval = 0 with fval = 1 -> FRAME; eol marks the last emitted pixel. fval = 0 -> GAP; set err trunc; pulse eol and eof together with pix_vld = 0.

Counting and checks:
- pixel counter counts pixels in the current line; line counter counts completed lines. Both saturate at 2^CW-1 and never wrap.
- First line of a frame sets the reference width. Any later line of different length sets err width at its eol.
- At eof, load frm_w and frm_h and pulse geom_vld. If a previous frame was completed since init and either dimension differs, set err geom. The first frame after init never sets geom.
- A zero-line frame (fval pulse with no lval) still produces eof and geom_vld with frm_h = 0 and frm_w = 0.

Reset values: pix = 0; all strobes 0; frm_w = frm_h = 0; err_stat = 0; FSM = SYNC. init mid-frame aborts immediately, with no eof.

## Timing
- All outputs are registered. Latency is 1 clk: a word presented with din_vld at edge N appears on pix/strobes after edge N.
- Because eol requires seeing the next word, pixels are delayed by one extra stage. Total din-to-pix latency is 2 valid words. Strobes stay aligned with their pixel.
- eof/geom_vld are asserted on the cycle following the word carrying the fval falling edge. err_stat bits set in that same cycle.
- Between valid words (din_vld = 0) all pulse outputs are 0; held pixel data is not re-emitted.

## Structure
- Shared package cl_pkg: bit-position constants (FVAL_BIT = 25, LVAL_BIT = 24, DVAL_BIT = 26), the err_stat bit index constants, and the FSM state enum (SYNC, GAP, FRAME, LINE).
- A natural sub-module is cl_unpack: a combinational din -> {fval, lval, pix} mapper, reused by the transmitter-side loopback checker.

## Test plan
- Reset while fval = 1 mid-line -> no output until fval = 0; the next full 4-line x 8-pixel frame gives sof once, 4 sol/eol pairs, eof, frm_w = 8, frm_h = 4.
- Pixel value 16'hA55A packed via the transmitter mapping -> pix = 16'hA55A, two valid words later.
- Frame 1 of 8x4 then frame 2 of 8x5 -> err_stat[3] set at frame-2 eof, frm_h = 5; frame 1 sets no error.
- fval drops during line 2 after 3 pixels -> eol and eof together, err_stat[1] set, frm_h = 1.
- lval pulse during fval = 0 -> no pix_vld, err_stat[0] set; err_clr clears it next cycle.
- din_vld toggling every other cycle across a 4x2 frame -> identical pixel/strobe sequence, with gaps only.
